// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, access sizes, FSM states.
package lsu_pkg;

  localparam int IDX_W = 6;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef enum logic {IDLE, MERGE} state_t;

  // Illegal codes fall through to a word access.
  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: return SZ_B;
      OP_H, OP_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: little-endian load extract/extend and store merge into a word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    b     = word[{lo, 3'b000} +: 8];
    h     = lo[1] ? word[31:16] : word[15:0];
    sx    = ~op[2];
    ldata = word;
    mword = word;
    case (op_size(op))
      SZ_B: begin
        ldata = {{24{sx & b[7]}}, b};
        mword[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ldata = {{16{sx & h[15]}}, h};
        if (lo[1]) mword[31:16] = wdata[15:0];
        else       mword[15:0]  = wdata[15:0];
      end
      default: begin
        ldata = word;
        mword = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses instead of truncating the address.
module lsu
  import lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [2:0]           op,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic                 exc,
  output logic [IDX_W-1:0]     dm_addr,
  output logic                 dm_rd,
  output logic                 dm_wr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata
);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic [2:0]       op_q;
  logic [31:0]      word_q;
  logic [31:0]      wdata_q;
  logic             exc_q;

  size_t            sz;
  logic             accept;
  logic             misal;
  logic             in_merge;
  logic [2:0]       lane_op;
  logic [1:0]       lane_lo;
  logic [31:0]      lane_word;
  logic [31:0]      lane_wdata;
  logic [31:0]      ldata;
  logic [31:0]      mword;
  logic             unused_addr;

  assign unused_addr = ^addr[31:8];

  assign sz       = op_size(op);
  assign in_merge = (state == MERGE);
  assign accept   = !in_merge && req && !rst;

`ifdef LSU_MISALIGN_EXC_EN
  assign misal = ((sz == SZ_H) && addr[0]) || ((sz == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // One lane instance serves both phases: live request in IDLE, captured request in MERGE.
  assign lane_op    = in_merge ? op_q    : op;
  assign lane_lo    = in_merge ? lo_q    : addr[1:0];
  assign lane_word  = in_merge ? word_q  : dm_rdata;
  assign lane_wdata = in_merge ? wdata_q : wdata;

  lsu_lane u_lane (
    .op    (lane_op),
    .lo    (lane_lo),
    .word  (lane_word),
    .wdata (lane_wdata),
    .ldata (ldata),
    .mword (mword)
  );

  assign busy     = in_merge;
  assign exc      = exc_q;
  assign dm_rd    = 1'b0;
  assign dm_addr  = in_merge ? idx_q : addr[7:2];
  assign dm_wdata = in_merge ? mword : wdata;
  // Reset gates the write combinationally so an aborted merge never reaches memory.
  assign dm_wr    = !rst && (in_merge || (accept && we && (sz == SZ_W) && !misal));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      exc_q   <= 1'b0;
      rdata   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      done  <= 1'b0;
      exc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= addr[7:2];
            lo_q    <= addr[1:0];
            op_q    <= op;
            word_q  <= dm_rdata;
            wdata_q <= wdata;
            if (misal) begin
              done  <= 1'b1;
              exc_q <= 1'b1;
              rdata <= '0;
            end else if (we && (sz != SZ_W)) begin
              state <= MERGE;
            end else begin
              done  <= 1'b1;
              rdata <= we ? '0 : ldata;
            end
          end
        end
        MERGE: begin
          state <= IDLE;
          done  <= 1'b1;
          rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
